dmem: RTL and testbench

- Word-organised synchronous-write, combinational-read data memory for the single-cycle RISC-V core.
- Sits on the core's load/store path. ALU result drives `a`, rs2 data drives `wd`, MemWrite drives `we`, and `rd` feeds the result mux.
- Storage array is preloadable by simulation via hex file into hierarchical `RAM`.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem.sv | 42 ++++
 tb/tb_dmem.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the word-organised data memory.
package dmem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;

    typedef logic [XLEN-1:0] word_t;

    // True when every address bit above the word index is zero.
    function automatic logic addr_in_range(input word_t addr, input int unsigned aw);
        return (addr >> (aw + 2)) == '0;
    endfunction

endpackage

// File: rtl/dmem.sv
// Data memory: combinational read, synchronous full-word write, no reset clearing.
module dmem
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN  = dmem_pkg::XLEN,
    parameter int unsigned DEPTH = dmem_pkg::DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd
);

    logic [XLEN-1:0] RAM [0:DEPTH-1];

    logic [AW-1:0] idx;
    logic          in_range;
    logic          wr_en;
    logic          unused_a;

    // Byte offset is ignored, so accesses are forced to word alignment.
    assign unused_a = ^a[1:0];

    always_comb begin
        idx      = a[AW+1:2];
        in_range = addr_in_range(word_t'(a), AW);
        // Only a definite 1 on we writes; reset low at the edge blocks the write.
        wr_en    = reset_n && (we === 1'b1) && in_range;
        rd       = in_range ? RAM[idx] : '0;
    end

    // The array is left out of the reset so that preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            RAM[idx] <= wd;
        end
    end

endmodule

// File: tb/tb_dmem.sv
// Directed scoreboard bench for dmem: stimulus queues expected rd values, a monitor checks them.
module tb_dmem;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    bit   chk_tgl = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    dmem uut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .a       (a),
        .wd      (wd),
        .rd      (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples rd shortly after each request and compares with the queue head.
    initial begin
        forever begin
            @(chk_tgl);
            #1;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL monitor: rd=%08h with no expected value queued", rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rd !== e.exp) begin
                    bad++;
                    $display("FAIL %s: rd=%08h expected=%08h", e.name, rd, e.exp);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        q.push_back(e);
        chk_tgl = ~chk_tgl;
        #2;
    endtask

    task automatic check(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        a = addr;
        expect_now(name, exp);
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        we      = 1'b0;
        a       = 32'h100;
        wd      = 32'h0;

        check(32'h100, 32'h0000_0000, "reset_oor_read");
        @(negedge clk);
        reset_n = 1'b1;

        // Preload
        write(32'h00, 32'h00C0_FFEE);
        write(32'h20, 32'h1111_1111);
        write(32'h30, 32'h3333_3333);
        write(32'hFC, 32'h5A5A_5A5A);
        check(32'hFC, 32'h5A5A_5A5A, "last_word");

        write(32'h10, 32'hDEAD_BEEF);
        check(32'h10, 32'hDEAD_BEEF, "wr_rb_0x10");

        write(32'h14, 32'hCAFE_BABE);
        check(32'h14, 32'hCAFE_BABE, "wr_rb_0x14");
        check(32'h10, 32'hDEAD_BEEF, "isolation_0x10");

        // Read during write: old value before the edge, new one right after it.
        @(negedge clk);
        a  = 32'h20;
        wd = 32'h2222_2222;
        we = 1'b1;
        expect_now("rdw_before", 32'h1111_1111);
        @(posedge clk);
        expect_now("rdw_after", 32'h2222_2222);
        we = 1'b0;

        write(32'h23, 32'h0BAD_F00D);
        check(32'h20, 32'h0BAD_F00D, "misalign_0x20");
        check(32'h21, 32'h0BAD_F00D, "misalign_0x21");
        check(32'h23, 32'h0BAD_F00D, "misalign_0x23");

        write(32'h100, 32'hFFFF_FFFF);
        check(32'h100, 32'h0000_0000, "oor_read");
        check(32'h00, 32'h00C0_FFEE, "oor_no_alias_0");
        check(32'h10, 32'hDEAD_BEEF, "oor_intact_0x10");
        check(32'hFC, 32'h5A5A_5A5A, "oor_intact_0xfc");

        // Reset asserted between edges blocks writes but not reads.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        a  = 32'h10;
        wd = 32'h1234_5678;
        we = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_now("rst_no_write", 32'hDEAD_BEEF);
        we = 1'b0;
        check(32'h20, 32'h0BAD_F00D, "rst_preload_0x20");
        check(32'h00, 32'h00C0_FFEE, "rst_preload_0x00");
        @(negedge clk);
        reset_n = 1'b1;
        write(32'h10, 32'h1234_5678);
        check(32'h10, 32'h1234_5678, "post_rst_write");

        // we low over several edges
        @(negedge clk);
        a  = 32'h30;
        wd = 32'hAAAA_AAAA;
        we = 1'b0;
        repeat (3) @(posedge clk);
        check(32'h30, 32'h3333_3333, "we0_hold");

        #10;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

endmodule
